// File: rtl/direction_ctrl.sv
// Steering and pacing stage ahead of control: turns PS/2 key events into per-player
// directions, blocks 180-degree reversals, and issues a P1/P2 step pair every move tick.
package direction_ctrl_pkg;
    typedef enum logic [1:0] {START = 2'd0, PLAY = 2'd1, GAME_OVER = 2'd2} game_mode;
    typedef enum logic [2:0] {WAIT = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4} directions;
endpackage

module direction_ctrl
    import direction_ctrl_pkg::*;
#(
    parameter int         TICK_DIV     = 6_500_000,
    parameter logic [7:0] KEY_P1_UP    = 8'h1D,
    parameter logic [7:0] KEY_P1_LEFT  = 8'h1C,
    parameter logic [7:0] KEY_P1_DOWN  = 8'h1B,
    parameter logic [7:0] KEY_P1_RIGHT = 8'h23,
    parameter logic [7:0] KEY_P2_UP    = 8'h75,
    parameter logic [7:0] KEY_P2_LEFT  = 8'h6B,
    parameter logic [7:0] KEY_P2_DOWN  = 8'h72,
    parameter logic [7:0] KEY_P2_RIGHT = 8'h74
) (
    input  logic       clk,
    input  logic       rst,
    input  game_mode   mode,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_break,
    input  logic       player1_collision,
    input  logic       player2_collision,
    output directions  direction_1,
    output directions  direction_2,
    output logic [1:0] selected_player,
    output logic       frozen
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    // The two STEP cycles belong to the tick period, so later ticks skip the first two counts.
    localparam logic [CW-1:0] CNT_RELOAD = CW'(2);

    typedef enum logic [1:0] {IDLE = 2'd0, STEP1 = 2'd1, STEP2 = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    directions       pend1_q, pend1_d, pend2_q, pend2_d;
    directions       dir1_q, dir1_d, dir2_q, dir2_d;
    logic            frozen_q, frozen_d;
    directions       k1, k2;
    logic            clear;

    function automatic logic is_opposite(input directions a, input directions b);
        return (a == UP && b == DOWN) || (a == DOWN && b == UP) ||
               (a == LEFT && b == RIGHT) || (a == RIGHT && b == LEFT);
    endfunction

    // WAIT on k1/k2 means "no key for this player this cycle".
    always_comb begin
        k1 = WAIT;
        k2 = WAIT;
        if (key_valid && !key_break) begin
            if (!key_ext) begin
                if      (key_code == KEY_P1_UP)    k1 = UP;
                else if (key_code == KEY_P1_LEFT)  k1 = LEFT;
                else if (key_code == KEY_P1_DOWN)  k1 = DOWN;
                else if (key_code == KEY_P1_RIGHT) k1 = RIGHT;
            end else begin
                if      (key_code == KEY_P2_UP)    k2 = UP;
                else if (key_code == KEY_P2_LEFT)  k2 = LEFT;
                else if (key_code == KEY_P2_DOWN)  k2 = DOWN;
                else if (key_code == KEY_P2_RIGHT) k2 = RIGHT;
            end
        end
    end

    always_comb begin
        clear    = rst || (mode == START);
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir1_d   = dir1_q;
        dir2_d   = dir2_q;
        frozen_d = frozen_q || player1_collision || player2_collision;
        pend1_d  = (k1 != WAIT && !is_opposite(k1, dir1_q)) ? k1 : pend1_q;
        pend2_d  = (k2 != WAIT && !is_opposite(k2, dir2_q)) ? k2 : pend2_q;

        unique case (state_q)
            IDLE: begin
                // A collision seen this cycle already blocks the next step pair.
                if (frozen_d) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_RELOAD;
                    state_d = STEP1;
                    dir1_d  = pend1_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STEP1: begin
                state_d = STEP2;
                dir2_d  = pend2_q;
            end
            STEP2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            pend1_d  = WAIT;
            pend2_d  = WAIT;
            dir1_d   = WAIT;
            dir2_d   = WAIT;
            frozen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend1_q  <= WAIT;
            pend2_q  <= WAIT;
            dir1_q   <= WAIT;
            dir2_q   <= WAIT;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend2_d;
            dir1_q   <= dir1_d;
            dir2_q   <= dir2_d;
            frozen_q <= frozen_d;
        end
    end

    assign direction_1     = dir1_q;
    assign direction_2     = dir2_q;
    assign frozen          = frozen_q;
    assign selected_player = (state_q == STEP1) ? 2'b01 :
                             (state_q == STEP2) ? 2'b11 : 2'b00;
endmodule
